// File: rtl/trn_tx_arb.sv
// trn_tx_arb: two-master arbiter for the PCIe TRN transmit channel.
//
// The rx path (write-back / notification TLPs) and the tx path (DMA read
// requests / completion notifications) share one TRN tx port on the endpoint
// core. Ownership is negotiated with req_ep -> my_trn, and the owner signals
// that it is actually driving the bus with drv_ep. The owner's TRN tx signals
// are muxed combinationally onto the core; everything else sees an idle bus.
// The arbiter also owns the shared non-posted tag counter, advanced by the
// owner's tag_inc.
//
// Ports:
//   clk, rst                     PCIe user clock; asynchronous active-high reset
//   {rx,tx}_req_ep               requester wants the TRN tx channel
//   {rx,tx}_drv_ep               requester is driving its TRN signals
//   {rx,tx}_tag_inc              requester consumed tag_trn; advance it
//   {rx,tx}_my_trn               registered grant to that requester
//   {rx,tx}_trn_*                requester TRN tx signals (td, trem_n, framing)
//   trn_td .. trn_tsrc_rdy_n     muxed TRN tx signals to the core
//   trn_tdst_rdy_n               core backpressure
//   tag_trn                      current shared tag
//   arb_err                      sticky protocol-violation flag

module trn_tx_arb #(
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             rx_req_ep,
  input  logic             tx_req_ep,
  input  logic             rx_drv_ep,
  input  logic             tx_drv_ep,
  input  logic             rx_tag_inc,
  input  logic             tx_tag_inc,
  output logic             rx_my_trn,
  output logic             tx_my_trn,

  input  logic [63:0]      rx_trn_td,
  input  logic [63:0]      tx_trn_td,
  input  logic [7:0]       rx_trn_trem_n,
  input  logic [7:0]       tx_trn_trem_n,
  input  logic             rx_trn_tsof_n,
  input  logic             tx_trn_tsof_n,
  input  logic             rx_trn_teof_n,
  input  logic             tx_trn_teof_n,
  input  logic             rx_trn_tsrc_rdy_n,
  input  logic             tx_trn_tsrc_rdy_n,

  output logic [63:0]      trn_td,
  output logic [7:0]       trn_trem_n,
  output logic             trn_tsof_n,
  output logic             trn_teof_n,
  output logic             trn_tsrc_rdy_n,
  input  logic             trn_tdst_rdy_n,

  output logic [TAG_W-1:0] tag_trn,
  output logic             arb_err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GNT_RX = 2'd1;
  localparam logic [1:0] ST_GNT_TX = 2'd2;

  localparam logic OWNER_RX = 1'b0;
  localparam logic OWNER_TX = 1'b1;

  logic [1:0]       state_q, state_d;
  logic             last_owner_q, last_owner_d;
  logic             in_pkt_q, in_pkt_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             err_q, err_d;
  logic             rx_gnt_q, rx_gnt_d;
  logic             tx_gnt_q, tx_gnt_d;

  logic own_rx, own_tx;
  logic own_tag_inc;
  logic beat_acc, sof_acc, eof_acc;
  logic nonown_drv, nonown_tag, sof_in_pkt;

  // ---------------------------------------------------------------------------
  // Ownership decode
  // ---------------------------------------------------------------------------
  always_comb begin
    own_rx      = (state_q == ST_GNT_RX);
    own_tx      = (state_q == ST_GNT_TX);
    own_tag_inc = (own_rx & rx_tag_inc) | (own_tx & tx_tag_inc);
  end

  // ---------------------------------------------------------------------------
  // Combinational TRN mux. Only an owner that is also driving reaches the
  // core; a non-owner's signals are never forwarded, even while it misbehaves.
  // ---------------------------------------------------------------------------
  always_comb begin
    trn_td         = 64'd0;
    trn_trem_n     = 8'hFF;
    trn_tsof_n     = 1'b1;
    trn_teof_n     = 1'b1;
    trn_tsrc_rdy_n = 1'b1;
    if (own_rx && rx_drv_ep) begin
      trn_td         = rx_trn_td;
      trn_trem_n     = rx_trn_trem_n;
      trn_tsof_n     = rx_trn_tsof_n;
      trn_teof_n     = rx_trn_teof_n;
      trn_tsrc_rdy_n = rx_trn_tsrc_rdy_n;
    end else if (own_tx && tx_drv_ep) begin
      trn_td         = tx_trn_td;
      trn_trem_n     = tx_trn_trem_n;
      trn_tsof_n     = tx_trn_tsof_n;
      trn_teof_n     = tx_trn_teof_n;
      trn_tsrc_rdy_n = tx_trn_tsrc_rdy_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Packet tracking. Acceptance is judged on what the core actually sees, so
  // a beat only counts if the owner is driving it.
  // ---------------------------------------------------------------------------
  always_comb begin
    beat_acc = ~trn_tsrc_rdy_n & ~trn_tdst_rdy_n;
    sof_acc  = beat_acc & ~trn_tsof_n;
    eof_acc  = beat_acc & ~trn_teof_n;

    in_pkt_d = in_pkt_q;
    // EOF wins so a single-beat TLP (SOF and EOF together) leaves in_pkt clear.
    if (eof_acc) begin
      in_pkt_d = 1'b0;
    end else if (sof_acc) begin
      in_pkt_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Tag counter: wraps naturally at 2^TAG_W.
  // ---------------------------------------------------------------------------
  always_comb begin
    tag_d = tag_q + TAG_W'(own_tag_inc);
  end

  // ---------------------------------------------------------------------------
  // Protocol-violation detection (sticky). In IDLE nobody owns the channel,
  // so any drv_ep or tag_inc there is a violation as well.
  // ---------------------------------------------------------------------------
  always_comb begin
    nonown_drv = (rx_drv_ep & ~own_rx) | (tx_drv_ep & ~own_tx);
    nonown_tag = (rx_tag_inc & ~own_rx) | (tx_tag_inc & ~own_tx);
    sof_in_pkt = sof_acc & in_pkt_q;
    err_d      = err_q | nonown_drv | nonown_tag | sof_in_pkt;
  end

  // ---------------------------------------------------------------------------
  // Grant FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_req_ep && tx_req_ep) begin
          // Round-robin: the requester that did not own the channel last wins.
          state_d = (last_owner_q == OWNER_RX) ? ST_GNT_TX : ST_GNT_RX;
        end else if (rx_req_ep) begin
          state_d = ST_GNT_RX;
        end else if (tx_req_ep) begin
          state_d = ST_GNT_TX;
        end
      end
      ST_GNT_RX: begin
        // Never release mid-packet, even if the owner drops its request early.
        if (!rx_req_ep && !rx_drv_ep && !in_pkt_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_GNT_TX: begin
        if (!tx_req_ep && !tx_drv_ep && !in_pkt_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_q == ST_IDLE && state_d == ST_GNT_RX) begin
      last_owner_d = OWNER_RX;
    end else if (state_q == ST_IDLE && state_d == ST_GNT_TX) begin
      last_owner_d = OWNER_TX;
    end

    // Grants come from dedicated flops so my_trn is glitch-free.
    rx_gnt_d = (state_d == ST_GNT_RX);
    tx_gnt_d = (state_d == ST_GNT_TX);
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_owner_q <= OWNER_TX;
      in_pkt_q     <= 1'b0;
      tag_q        <= '0;
      err_q        <= 1'b0;
      rx_gnt_q     <= 1'b0;
      tx_gnt_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      in_pkt_q     <= in_pkt_d;
      tag_q        <= tag_d;
      err_q        <= err_d;
      rx_gnt_q     <= rx_gnt_d;
      tx_gnt_q     <= tx_gnt_d;
    end
  end

  assign rx_my_trn = rx_gnt_q;
  assign tx_my_trn = tx_gnt_q;
  assign tag_trn   = tag_q;
  assign arb_err   = err_q;

endmodule

// File: tb/tb_trn_tx_arb.sv
// Bench for trn_tx_arb. Stimulus pushes expectations into queues; a monitor
// on the falling edge pops and compares: point checks by cycle stamp,
// forwarded beats whenever the core accepts one, and grant order whenever a
// grant rises.

module tb_trn_tx_arb;

  localparam int TAG_W = 5;

  localparam int S_RXG  = 0;
  localparam int S_TXG  = 1;
  localparam int S_TAG  = 2;
  localparam int S_ERR  = 3;
  localparam int S_TSRC = 4;
  localparam int S_TD   = 5;
  localparam int S_TREM = 6;
  localparam int S_TSOF = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rx_req_ep, tx_req_ep, rx_drv_ep, tx_drv_ep;
  logic             rx_tag_inc, tx_tag_inc;
  logic             rx_my_trn, tx_my_trn;
  logic [63:0]      rx_trn_td, tx_trn_td;
  logic [7:0]       rx_trn_trem_n, tx_trn_trem_n;
  logic             rx_trn_tsof_n, tx_trn_tsof_n, rx_trn_teof_n, tx_trn_teof_n;
  logic             rx_trn_tsrc_rdy_n, tx_trn_tsrc_rdy_n;
  logic [63:0]      trn_td;
  logic [7:0]       trn_trem_n;
  logic             trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tdst_rdy_n;
  logic [TAG_W-1:0] tag_trn;
  logic             arb_err;

  trn_tx_arb #(.TAG_W(TAG_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .rx_req_ep         (rx_req_ep),
    .tx_req_ep         (tx_req_ep),
    .rx_drv_ep         (rx_drv_ep),
    .tx_drv_ep         (tx_drv_ep),
    .rx_tag_inc        (rx_tag_inc),
    .tx_tag_inc        (tx_tag_inc),
    .rx_my_trn         (rx_my_trn),
    .tx_my_trn         (tx_my_trn),
    .rx_trn_td         (rx_trn_td),
    .tx_trn_td         (tx_trn_td),
    .rx_trn_trem_n     (rx_trn_trem_n),
    .tx_trn_trem_n     (tx_trn_trem_n),
    .rx_trn_tsof_n     (rx_trn_tsof_n),
    .tx_trn_tsof_n     (tx_trn_tsof_n),
    .rx_trn_teof_n     (rx_trn_teof_n),
    .tx_trn_teof_n     (tx_trn_teof_n),
    .rx_trn_tsrc_rdy_n (rx_trn_tsrc_rdy_n),
    .tx_trn_tsrc_rdy_n (tx_trn_tsrc_rdy_n),
    .trn_td            (trn_td),
    .trn_trem_n        (trn_trem_n),
    .trn_tsof_n        (trn_tsof_n),
    .trn_teof_n        (trn_teof_n),
    .trn_tsrc_rdy_n    (trn_tsrc_rdy_n),
    .trn_tdst_rdy_n    (trn_tdst_rdy_n),
    .tag_trn           (tag_trn),
    .arb_err           (arb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          sel;
    logic [63:0] exp;
    string       name;
  } chk_t;

  typedef struct {
    logic [63:0] td;
    logic [7:0]  trem;
    logic        sof_n;
    logic        eof_n;
  } beat_t;

  typedef struct {
    bit who;   // 0 = rx, 1 = tx
    int gap;   // required idle cycles before this grant, -1 = don't care
  } gnt_t;

  chk_t  chk_q[$];
  beat_t beat_q[$];
  gnt_t  gnt_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [63:0] actual(int sel);
    case (sel)
      S_RXG:   return {63'd0, rx_my_trn};
      S_TXG:   return {63'd0, tx_my_trn};
      S_TAG:   return {{(64-TAG_W){1'b0}}, tag_trn};
      S_ERR:   return {63'd0, arb_err};
      S_TSRC:  return {63'd0, trn_tsrc_rdy_n};
      S_TD:    return trn_td;
      S_TREM:  return {56'd0, trn_trem_n};
      default: return {63'd0, trn_tsof_n};
    endcase
  endfunction

  // Monitor
  initial begin
    chk_t  c;
    beat_t b;
    gnt_t  g;
    logic  prev_rx = 1'b0;
    logic  prev_tx = 1'b0;
    int    idle_cnt = 0;
    logic [63:0] a;
    forever begin
      @(negedge clk);
      while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
        c = chk_q.pop_front();
        a = actual(c.sel);
        checks++;
        if (a !== c.exp) begin
          failures++;
          $display("FAIL %s cyc=%0d actual=%0h required=%0h", c.name, cyc, a, c.exp);
        end
      end

      if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
        checks++;
        if (beat_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat cyc=%0d actual td=%0h required none", cyc, trn_td);
        end else begin
          b = beat_q.pop_front();
          if ({trn_td, trn_trem_n, trn_tsof_n, trn_teof_n} !== {b.td, b.trem, b.sof_n, b.eof_n})
          begin
            failures++;
            $display("FAIL beat cyc=%0d actual td=%0h trem=%0h sof_n=%0b eof_n=%0b required td=%0h trem=%0h sof_n=%0b eof_n=%0b",
                     cyc, trn_td, trn_trem_n, trn_tsof_n, trn_teof_n,
                     b.td, b.trem, b.sof_n, b.eof_n);
          end
        end
      end

      checks++;
      if (rx_my_trn && tx_my_trn) begin
        failures++;
        $display("FAIL exclusive_grant cyc=%0d actual both=1 required at most one", cyc);
      end

      if ((rx_my_trn && !prev_rx) || (tx_my_trn && !prev_tx)) begin
        checks++;
        if (gnt_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_grant cyc=%0d actual tx=%0b required none", cyc, tx_my_trn);
        end else begin
          g = gnt_q.pop_front();
          if (tx_my_trn !== g.who || (g.gap >= 0 && idle_cnt != g.gap)) begin
            failures++;
            $display("FAIL grant_order cyc=%0d actual who=%0b gap=%0d required who=%0b gap=%0d",
                     cyc, tx_my_trn, idle_cnt, g.who, g.gap);
          end
        end
        idle_cnt = 0;
      end else if (!rx_my_trn && !tx_my_trn) begin
        idle_cnt++;
      end
      prev_rx = rx_my_trn;
      prev_tx = tx_my_trn;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(string nm, int sel, logic [63:0] v);
    chk_t c;
    c.cyc  = cyc;
    c.sel  = sel;
    c.exp  = v;
    c.name = nm;
    chk_q.push_back(c);
  endtask

  task automatic expect_gnt(string nm, bit who, logic v);
    expect_now(nm, who ? S_TXG : S_RXG, {63'd0, v});
  endtask

  task automatic push_gnt(bit who, int gap);
    gnt_t g;
    g.who = who;
    g.gap = gap;
    gnt_q.push_back(g);
  endtask

  task automatic set_req(bit who, logic v);
    if (who) tx_req_ep = v;
    else     rx_req_ep = v;
  endtask

  task automatic drive(bit who, logic drv, logic [63:0] td, logic [7:0] trem,
                       logic sof_n, logic eof_n, logic src_n);
    if (who) begin
      tx_drv_ep = drv; tx_trn_td = td; tx_trn_trem_n = trem;
      tx_trn_tsof_n = sof_n; tx_trn_teof_n = eof_n; tx_trn_tsrc_rdy_n = src_n;
    end else begin
      rx_drv_ep = drv; rx_trn_td = td; rx_trn_trem_n = trem;
      rx_trn_tsof_n = sof_n; rx_trn_teof_n = eof_n; rx_trn_tsrc_rdy_n = src_n;
    end
  endtask

  task automatic idle_bus(bit who);
    drive(who, 1'b0, 64'd0, 8'hFF, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic beat(bit who, logic [63:0] td, logic [7:0] trem, logic sof_n, logic eof_n);
    beat_t b;
    drive(who, 1'b1, td, trem, sof_n, eof_n, 1'b0);
    b.td = td; b.trem = trem; b.sof_n = sof_n; b.eof_n = eof_n;
    beat_q.push_back(b);
  endtask

  // Drives nb beats on consecutive cycles, starting now; ends in the last beat cycle.
  task automatic send_tlp(bit who, int nb, logic [63:0] base);
    for (int i = 0; i < nb; i++) begin
      beat(who, base + 64'(i), (i == nb - 1) ? 8'h0F : 8'h00,
           (i != 0), (i != nb - 1));
      if (i < nb - 1) step();
    end
  endtask

  task automatic release_gnt(bit who);
    step();
    set_req(who, 1'b0);
    idle_bus(who);
    expect_gnt("release_hold", who, 1'b1);
    step();
    expect_gnt("release_drop", who, 1'b0);
  endtask

  task automatic wait_grant(bit who);
    int n = 0;
    while (!(who ? tx_my_trn : rx_my_trn) && n < 20) begin
      step();
      n++;
    end
    if (!(who ? tx_my_trn : rx_my_trn)) begin
      checks++;
      failures++;
      $display("FAIL grant_timeout who=%0b actual my_trn=0 required 1", who);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rx_req_ep = 1'b0; tx_req_ep = 1'b0;
    rx_tag_inc = 1'b0; tx_tag_inc = 1'b0;
    idle_bus(1'b0);
    idle_bus(1'b1);
    trn_tdst_rdy_n = 1'b0;

    // Reset state
    step();
    expect_now("rst_rx_my",  S_RXG,  64'd0);
    expect_now("rst_tx_my",  S_TXG,  64'd0);
    expect_now("rst_tag",    S_TAG,  64'd0);
    expect_now("rst_err",    S_ERR,  64'd0);
    expect_now("rst_tsrc",   S_TSRC, 64'd1);
    expect_now("rst_trem",   S_TREM, 64'hFF);
    expect_now("rst_td",     S_TD,   64'd0);
    step();
    rst = 1'b0;

    // RX alone
    step();
    rx_req_ep = 1'b1;
    push_gnt(1'b0, -1);
    expect_gnt("rx_alone_pre", 1'b0, 1'b0);
    step();
    expect_gnt("rx_alone_gnt", 1'b0, 1'b1);
    expect_gnt("rx_alone_txg", 1'b1, 1'b0);
    step();
    send_tlp(1'b0, 3, 64'hA5A5_0000_0000_0010);
    release_gnt(1'b0);
    expect_gnt("rx_alone_tx_idle", 1'b1, 1'b0);

    // Contention after reset: RX, TX, RX with one dead cycle between
    do_reset();
    step();
    rx_req_ep = 1'b1;
    tx_req_ep = 1'b1;
    push_gnt(1'b0, -1);
    push_gnt(1'b1, 1);
    push_gnt(1'b0, 1);
    step();
    expect_gnt("cont_rx1", 1'b0, 1'b1);
    send_tlp(1'b0, 1, 64'h1111_2222_3333_4444);
    step();
    set_req(1'b0, 1'b0);
    idle_bus(1'b0);
    step();
    expect_gnt("cont_dead1_rx", 1'b0, 1'b0);
    expect_gnt("cont_dead1_tx", 1'b1, 1'b0);
    set_req(1'b0, 1'b1);
    step();
    expect_gnt("cont_tx", 1'b1, 1'b1);
    send_tlp(1'b1, 1, 64'h5555_6666_7777_8888);
    step();
    set_req(1'b1, 1'b0);
    idle_bus(1'b1);
    step();
    expect_gnt("cont_dead2_tx", 1'b1, 1'b0);
    step();
    expect_gnt("cont_rx2", 1'b0, 1'b1);
    send_tlp(1'b0, 2, 64'h9999_0000_AAAA_0000);
    release_gnt(1'b0);

    // Early release guard (TX)
    step();
    set_req(1'b1, 1'b1);
    push_gnt(1'b1, -1);
    wait_grant(1'b1);
    beat(1'b1, 64'hC0DE_0000_0000_0001, 8'h00, 1'b0, 1'b1);
    step();
    set_req(1'b1, 1'b0);
    idle_bus(1'b1);
    expect_gnt("guard_hold1", 1'b1, 1'b1);
    step();
    expect_gnt("guard_hold2", 1'b1, 1'b1);
    step();
    expect_gnt("guard_hold3", 1'b1, 1'b1);
    step();
    beat(1'b1, 64'hC0DE_0000_0000_0002, 8'h0F, 1'b1, 1'b0);
    expect_gnt("guard_eof", 1'b1, 1'b1);
    release_gnt(1'b1);

    // Backpressure (RX)
    step();
    set_req(1'b0, 1'b1);
    push_gnt(1'b0, -1);
    wait_grant(1'b0);
    beat(1'b0, 64'hBEEF_0000_0000_0001, 8'h00, 1'b0, 1'b1);
    step();
    trn_tdst_rdy_n = 1'b1;
    beat(1'b0, 64'hBEEF_0000_0000_0002, 8'h00, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      expect_now("bp_td",   S_TD,   64'hBEEF_0000_0000_0002);
      expect_now("bp_tsrc", S_TSRC, 64'd0);
      expect_gnt("bp_gnt", 1'b0, 1'b1);
      if (k < 3) step();
    end
    step();
    trn_tdst_rdy_n = 1'b0;
    expect_now("bp_err", S_ERR, 64'd0);
    step();
    beat(1'b0, 64'hBEEF_0000_0000_0003, 8'h0F, 1'b1, 1'b0);
    release_gnt(1'b0);

    // Tags (TX owner), then a non-owner tag_inc and drv_ep
    step();
    set_req(1'b1, 1'b1);
    push_gnt(1'b1, -1);
    wait_grant(1'b1);
    for (int k = 0; k < 33; k++) begin
      tx_tag_inc = 1'b1;
      expect_now("tag_seq", S_TAG, 64'(k % 32));
      step();
    end
    tx_tag_inc = 1'b0;
    expect_now("tag_after_wrap", S_TAG, 64'd1);
    expect_now("tag_err_clean", S_ERR, 64'd0);
    step();
    rx_tag_inc = 1'b1;
    expect_now("nonown_tag_pre_err", S_ERR, 64'd0);
    step();
    rx_tag_inc = 1'b0;
    expect_now("nonown_tag_unchanged", S_TAG, 64'd1);
    expect_now("nonown_tag_err", S_ERR, 64'd1);
    drive(1'b0, 1'b1, 64'hDEAD_DEAD_DEAD_DEAD, 8'h00, 1'b0, 1'b0, 1'b0);
    expect_now("nonown_drv_td",   S_TD,   64'd0);
    expect_now("nonown_drv_tsrc", S_TSRC, 64'd1);
    expect_now("nonown_drv_tsof", S_TSOF, 64'd1);
    step();
    idle_bus(1'b0);
    expect_now("err_sticky1", S_ERR, 64'd1);
    release_gnt(1'b1);
    expect_now("err_sticky2", S_ERR, 64'd1);

    // Reset mid-packet (TX beat 2)
    step();
    set_req(1'b1, 1'b1);
    push_gnt(1'b1, -1);
    wait_grant(1'b1);
    beat(1'b1, 64'hF00D_0000_0000_0001, 8'h00, 1'b0, 1'b1);
    step();
    drive(1'b1, 1'b1, 64'hF00D_0000_0000_0002, 8'h00, 1'b1, 1'b1, 1'b0);
    #1;
    rst = 1'b1;
    expect_now("arst_tx_my", S_TXG,  64'd0);
    expect_now("arst_tsrc",  S_TSRC, 64'd1);
    expect_now("arst_td",    S_TD,   64'd0);
    expect_now("arst_tag",   S_TAG,  64'd0);
    expect_now("arst_err",   S_ERR,  64'd0);
    #5;
    rst = 1'b0;
    set_req(1'b1, 1'b0);
    idle_bus(1'b1);
    step();
    set_req(1'b0, 1'b1);
    push_gnt(1'b0, -1);
    expect_gnt("post_rst_pre", 1'b0, 1'b0);
    step();
    expect_gnt("post_rst_gnt", 1'b0, 1'b1);
    expect_gnt("post_rst_txg", 1'b1, 1'b0);
    step();
    set_req(1'b0, 1'b0);
    expect_gnt("post_rst_hold", 1'b0, 1'b1);
    step();
    // Release here only happens if in_pkt was cleared by the reset.
    expect_gnt("post_rst_release", 1'b0, 1'b0);
    expect_now("post_rst_err", S_ERR, 64'd0);
    step();
    step();

    checks++;
    if (beat_q.size() != 0 || gnt_q.size() != 0 || chk_q.size() != 0) begin
      failures++;
      $display("FAIL leftover actual beats=%0d grants=%0d checks=%0d required 0",
               beat_q.size(), gnt_q.size(), chk_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL time_limit actual running required finished");
    $fatal(1, "time limit");
  end

endmodule
